// File: rtl/counter_seq_pkg.sv
// Shared types and default widths for the counter run sequencer.
// The state encoding is fixed so software-visible debug reads stay stable.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_REP_W = 4;

endpackage

// File: rtl/up_counter.sv
// Free-running up-counter driven by the sequencer's clear/enable outputs.
// It has its own reset so a sequencer reset leaves the count untouched.
module up_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] value_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
        end else if (clear_i) begin
            value_q <= '0;
        end else if (en_i) begin
            value_q <= value_q + WIDTH'(1);
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/counter_sequencer.sv
// Run controller for an external up-counter: takes a (limit, repeat) command,
// sequences clear/count periods and reports per-period ticks and run completion.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic             abort,
    output logic             cnt_clear,
    output logic             cnt_en,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [REP_W-1:0] reps_done
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [REP_W-1:0] repTarget_q, repTarget_d;
    logic [REP_W-1:0] repCount_q, repCount_d;
    logic             tick_q, tick_d;
    logic [REP_W-1:0] repNext;
    logic             terminal;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            limit_q     <= '0;
            repTarget_q <= '0;
            repCount_q  <= '0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            limit_q     <= limit_d;
            repTarget_q <= repTarget_d;
            repCount_q  <= repCount_d;
            tick_q      <= tick_d;
        end
    end

    // >= rather than == so a counter that missed its clear still terminates.
    assign terminal = (cnt_value >= limit_q);
    assign repNext  = repCount_q + REP_W'(1);

    always_comb begin
        state_d     = state_q;
        limit_d     = limit_q;
        repTarget_d = repTarget_q;
        repCount_d  = repCount_q;
        tick_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    limit_d     = cmd_limit;
                    repTarget_d = cmd_reps;
                    repCount_d  = '0;
                    state_d     = CLEAR;
                end
            end
            CLEAR: begin
                state_d = abort ? IDLE : RUN;
            end
            RUN: begin
                // Abort outranks a terminal count: no tick, no increment.
                if (abort) begin
                    state_d = IDLE;
                end else if (terminal) begin
                    repCount_d = repNext;
                    tick_d     = 1'b1;
                    if ((repTarget_q != '0) && (repNext == repTarget_q)) begin
                        state_d = DONE;
                    end else begin
                        state_d = CLEAR;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign cnt_clear = (state_q == CLEAR);
    assign cnt_en    = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign tick      = tick_q;
    assign reps_done = repCount_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer plus the up_counter it drives,
// compared against an arithmetic model of the period/tick/done schedule.
module tb_counter_sequencer;

    localparam int WIDTH = 8;
    localparam int REP_W = 4;

    logic             clock = 1'b0;
    logic             rst = 1'b0;
    logic             cntRst = 1'b0;
    logic             cmdValid = 1'b0;
    logic             cmdReady;
    logic [WIDTH-1:0] cmdLimit = '0;
    logic [REP_W-1:0] cmdReps = '0;
    logic             abortIn = 1'b0;
    logic             cntClear;
    logic             cntEn;
    logic [WIDTH-1:0] cntValue;
    logic             busy;
    logic             tick;
    logic             done;
    logic [REP_W-1:0] repsDone;

    int testsRun = 0;
    int testsFailed = 0;

    counter_sequencer #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
        .clock     (clock),
        .reset     (rst),
        .cmd_valid (cmdValid),
        .cmd_ready (cmdReady),
        .cmd_limit (cmdLimit),
        .cmd_reps  (cmdReps),
        .abort     (abortIn),
        .cnt_clear (cntClear),
        .cnt_en    (cntEn),
        .cnt_value (cntValue),
        .busy      (busy),
        .tick      (tick),
        .done      (done),
        .reps_done (repsDone)
    );

    up_counter #(.WIDTH(WIDTH)) counter (
        .clock   (clock),
        .reset   (cntRst),
        .clear_i (cntClear),
        .en_i    (cntEn),
        .value_o (cntValue)
    );

    always #5 clock = ~clock;

    // Expected {busy, cmd_ready, cnt_clear, cnt_en, tick, done, reps_done}
    // on busy cycle c (1 = first cycle after acceptance) of a run.
    function automatic logic [9:0] expectedFlags(input int c, input int lim, input int reps);
        int p;
        int total;
        int off;
        logic isDone;
        logic isClear;
        logic isRun;
        logic expTick;
        p       = lim + 2;
        total   = reps * p + 1;
        off     = (c - 1) % p;
        isDone  = (reps != 0) && (c == total);
        isClear = !isDone && (off == 0);
        isRun   = !isDone && (off != 0);
        expTick = (c > 1) && (off == 0);
        return {1'b1, 1'b0, isClear, isRun, expTick, isDone, 4'(((c - 1) / p) % 16)};
    endfunction

    function automatic int expectedValue(input int c, input int lim);
        return ((c - 1) % (lim + 2)) - 1;
    endfunction

    task automatic test_reset();
        rst    = 1'b0;
        cntRst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            testsRun++;
            if ({busy, cmdReady, cntClear, cntEn, tick, done, repsDone} !== 10'b01_0000_0000) begin
                testsFailed++;
                $display("[TB] FAIL reset_hold cyc=%0d got %b exp %b", i,
                         {busy, cmdReady, cntClear, cntEn, tick, done, repsDone}, 10'b01_0000_0000);
            end
        end
        rst    = 1'b1;
        cntRst = 1'b1;
        @(negedge clock);
        testsRun++;
        if ({busy, cmdReady, cntClear, cntEn, tick, done, repsDone} !== 10'b01_0000_0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_release got %b exp %b",
                     {busy, cmdReady, cntClear, cntEn, tick, done, repsDone}, 10'b01_0000_0000);
        end
    endtask

    // Entered on an IDLE negedge; leaves on the first IDLE negedge after DONE,
    // so consecutive calls also exercise acceptance on that first IDLE cycle.
    task automatic test_finite_run(input int lim, input int reps);
        int total;
        int ticks;
        int dones;
        logic [9:0] exp;
        total = reps * (lim + 2) + 1;
        ticks = 0;
        dones = 0;
        testsRun++;
        if (cmdReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL run_ready lim=%0d got %b exp 1", lim, cmdReady);
        end
        cmdValid = 1'b1;
        cmdLimit = WIDTH'(lim);
        cmdReps  = REP_W'(reps);
        @(negedge clock);
        cmdValid = 1'b0;
        for (int c = 1; c <= total; c++) begin
            exp = expectedFlags(c, lim, reps);
            testsRun++;
            if ({busy, cmdReady, cntClear, cntEn, tick, done, repsDone} !== exp) begin
                testsFailed++;
                $display("[TB] FAIL run_flags lim=%0d reps=%0d c=%0d got %b exp %b", lim, reps, c,
                         {busy, cmdReady, cntClear, cntEn, tick, done, repsDone}, exp);
            end
            if (exp[6]) begin
                testsRun++;
                if (cntValue !== WIDTH'(expectedValue(c, lim))) begin
                    testsFailed++;
                    $display("[TB] FAIL run_value lim=%0d c=%0d got %0d exp %0d", lim, c,
                             cntValue, expectedValue(c, lim));
                end
            end
            ticks += int'(tick);
            dones += int'(done);
            @(negedge clock);
        end
        testsRun++;
        if ({busy, cmdReady, done, repsDone, ticks, dones} !== {3'b010, REP_W'(reps), reps, 1}) begin
            testsFailed++;
            $display("[TB] FAIL run_end lim=%0d reps=%0d got busy=%b ready=%b done=%b reps_done=%0d ticks=%0d dones=%0d exp ready=1 reps_done=%0d ticks=%0d dones=1",
                     lim, reps, busy, cmdReady, done, repsDone, ticks, dones, reps, reps);
        end
    endtask

    task automatic test_continuous();
        logic [9:0] exp;
        cmdValid = 1'b1;
        cmdLimit = WIDTH'(3);
        cmdReps  = '0;
        @(negedge clock);
        cmdValid = 1'b0;
        // 93 cycles covers the 15->0 wrap on tick 16 and stops mid-period.
        for (int c = 1; c <= 93; c++) begin
            exp = expectedFlags(c, 3, 0);
            testsRun++;
            if ({busy, cmdReady, cntClear, cntEn, tick, done, repsDone} !== exp) begin
                testsFailed++;
                $display("[TB] FAIL cont_flags c=%0d got %b exp %b", c,
                         {busy, cmdReady, cntClear, cntEn, tick, done, repsDone}, exp);
            end
            if (c < 93) @(negedge clock);
        end
        abortIn = 1'b1;
        @(negedge clock);
        abortIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            testsRun++;
            if ({busy, cmdReady, done, tick, repsDone} !== {4'b0100, 4'd2}) begin
                testsFailed++;
                $display("[TB] FAIL cont_abort i=%0d got busy=%b ready=%b done=%b tick=%b reps_done=%0d exp 0 1 0 0 2",
                         i, busy, cmdReady, done, tick, repsDone);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_abort_terminal();
        int lim;
        int p;
        int waited;
        lim = int'($urandom_range(1, 8));
        p   = lim + 2;
        cmdValid = 1'b1;
        cmdLimit = WIDTH'(lim);
        cmdReps  = REP_W'(3);
        @(negedge clock);
        cmdValid = 1'b0;
        repeat (p - 1) @(negedge clock);
        testsRun++;
        if ({cntEn, cntValue} !== {1'b1, WIDTH'(lim)}) begin
            testsFailed++;
            $display("[TB] FAIL abort_pre en=%b value=%0d exp en=1 value=%0d", cntEn, cntValue, lim);
        end
        abortIn  = 1'b1;
        cmdValid = 1'b1;
        cmdLimit = WIDTH'(2);
        cmdReps  = REP_W'(1);
        @(negedge clock);
        abortIn = 1'b0;
        testsRun++;
        if ({busy, cmdReady, tick, done, repsDone} !== {4'b0100, 4'd0}) begin
            testsFailed++;
            $display("[TB] FAIL abort_term got busy=%b ready=%b tick=%b done=%b reps_done=%0d exp 0 1 0 0 0",
                     busy, cmdReady, tick, done, repsDone);
        end
        @(negedge clock);
        cmdValid = 1'b0;
        testsRun++;
        if ({busy, cntClear, repsDone} !== {2'b11, 4'd0}) begin
            testsFailed++;
            $display("[TB] FAIL abort_accept got busy=%b clear=%b reps_done=%0d exp 1 1 0",
                     busy, cntClear, repsDone);
        end
        waited = 0;
        while (busy && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        testsRun++;
        if ({busy, repsDone} !== {1'b0, 4'd1}) begin
            testsFailed++;
            $display("[TB] FAIL abort_followup got busy=%b reps_done=%0d after %0d cycles exp 0 1",
                     busy, repsDone, waited);
        end
    endtask

    task automatic test_reset_midrun();
        cmdValid = 1'b1;
        cmdLimit = WIDTH'(2);
        cmdReps  = REP_W'(5);
        @(negedge clock);
        cmdValid = 1'b0;
        repeat (9) @(negedge clock);
        testsRun++;
        if ({busy, cntEn, repsDone} !== {2'b11, 4'd2}) begin
            testsFailed++;
            $display("[TB] FAIL midrst_pre got busy=%b en=%b reps_done=%0d exp 1 1 2", busy, cntEn, repsDone);
        end
        #2;
        rst = 1'b0;
        #1;
        testsRun++;
        if ({busy, cmdReady, cntClear, cntEn, tick, done, repsDone} !== 10'b01_0000_0000) begin
            testsFailed++;
            $display("[TB] FAIL midrst_async got %b exp %b",
                     {busy, cmdReady, cntClear, cntEn, tick, done, repsDone}, 10'b01_0000_0000);
        end
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        testsRun++;
        if ({busy, cmdReady, cntEn, repsDone} !== {3'b010, 4'd0}) begin
            testsFailed++;
            $display("[TB] FAIL midrst_after got busy=%b ready=%b en=%b reps_done=%0d exp 0 1 0 0",
                     busy, cmdReady, cntEn, repsDone);
        end
    endtask

    initial begin
        test_reset();
        test_finite_run(5, 2);
        test_finite_run(0, 3);
        test_continuous();
        test_abort_terminal();
        for (int i = 0; i < 4; i++) begin
            test_finite_run(int'($urandom_range(0, 12)), int'($urandom_range(1, 4)));
        end
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
